// File: rtl/pulse_trigger_info_reader_if.sv
// Pulse-trigger reader bus bundle: FIFO pop side, trigger record side, clear and status.
// master = the reader itself, slave = the surrounding FIFO / trigger processor.
interface pulse_trigger_info_reader_if;
    logic         fifo_valid;
    logic         fifo_ready;
    logic [127:0] fifo_data;
    logic         clear_counters;
    logic         trig_valid;
    logic         trig_ready;
    logic [23:0]  trig_num;
    logic [43:0]  trig_timestamp;
    logic [1:0]   trig_type;
    logic         trig_close;
    logic         seq_error;
    logic         format_error;
    logic [15:0]  missed_count;
    logic [23:0]  cnt_laser;
    logic [23:0]  cnt_am;
    logic [23:0]  cnt_both;
    logic [2:0]   state;

    modport master (
        input  fifo_valid, fifo_data, clear_counters, trig_ready,
        output fifo_ready, trig_valid, trig_num, trig_timestamp, trig_type, trig_close,
               seq_error, format_error, missed_count, cnt_laser, cnt_am, cnt_both, state
    );

    modport slave (
        output fifo_valid, fifo_data, clear_counters, trig_ready,
        input  fifo_ready, trig_valid, trig_num, trig_timestamp, trig_type, trig_close,
               seq_error, format_error, missed_count, cnt_laser, cnt_am, cnt_both, state
    );
endinterface

// File: rtl/pulse_trigger_info_reader.sv
// Pops trigger-info words, checks format/number continuity, counts per type; pop->trig_valid 2 cycles,
// holds record until trig_ready (FIFO not popped meanwhile). PTR_HOLDOFF_EN enables trig_close.
module pulse_trigger_info_reader #(
    parameter logic [43:0] HOLDOFF_CYCLES = 44'd8
) (
    input logic                          clk,
    input logic                          reset_n,
    pulse_trigger_info_reader_if.master  bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'b001,
        CHECK = 3'b010,
        SEND  = 3'b100
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic          w_fifo_ready;
    logic          w_trig_valid;

    logic [127:0]  r_word;
    logic [23:0]   r_expected;
    logic [15:0]   r_missed;
    logic [23:0]   r_cnt_laser;
    logic [23:0]   r_cnt_am;
    logic [23:0]   r_cnt_both;
    logic [23:0]   r_trig_num;
    logic [43:0]   r_trig_ts;
    logic [1:0]    r_trig_type;
    logic          r_seq_err;
    logic          r_fmt_err;

    logic [1:0]    w_type;
    logic [23:0]   w_num;
    logic [43:0]   w_ts;
    logic          w_fmt_bad;
    logic          w_check;
    logic          w_fwd;
    logic [23:0]   w_diff;
    logic [24:0]   w_missed_sum;
    logic [15:0]   w_missed_next;

    assign w_type    = r_word[69:68];
    assign w_num     = r_word[67:44];
    assign w_ts      = r_word[43:0];
    assign w_fmt_bad = (|r_word[127:70]) || (w_type == 2'b00);
    assign w_check   = (r_state == CHECK);
    assign w_fwd     = w_check && !w_fmt_bad;

    // Gap size is modular so a wrap-around jump still counts as missed triggers.
    assign w_diff        = w_num - r_expected;
    assign w_missed_sum  = {9'd0, r_missed} + {1'b0, w_diff};
    assign w_missed_next = (|w_missed_sum[24:16]) ? 16'hFFFF : w_missed_sum[15:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = IDLE;
        w_fifo_ready = 1'b0;
        w_trig_valid = 1'b0;
        case (r_state)
            IDLE: begin
                w_fifo_ready = 1'b1;
                w_next       = bus.fifo_valid ? CHECK : IDLE;
            end
            CHECK: begin
                w_next = w_fmt_bad ? IDLE : SEND;
            end
            SEND: begin
                w_trig_valid = 1'b1;
                w_next       = bus.trig_ready ? IDLE : SEND;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

`ifdef PTR_HOLDOFF_EN
    logic [43:0] r_prev_ts;
    logic        r_prev_vld;
    logic        r_close;
    logic [43:0] w_delta;
    logic        w_close;

    assign w_delta = w_ts - r_prev_ts;
    assign w_close = !bus.clear_counters && r_prev_vld && (w_delta < HOLDOFF_CYCLES);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev_ts  <= 44'd0;
            r_prev_vld <= 1'b0;
            r_close    <= 1'b0;
        end else begin
            if (w_fwd) begin
                r_close <= w_close;
            end
            if (bus.clear_counters) begin
                r_prev_vld <= 1'b0;
            end else if (w_fwd) begin
                r_prev_ts  <= w_ts;
                r_prev_vld <= 1'b1;
            end
        end
    end

    assign bus.trig_close = r_close;
`else
    assign bus.trig_close = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_word      <= 128'd0;
            r_expected  <= 24'd1;
            r_missed    <= 16'd0;
            r_cnt_laser <= 24'd0;
            r_cnt_am    <= 24'd0;
            r_cnt_both  <= 24'd0;
            r_trig_num  <= 24'd0;
            r_trig_ts   <= 44'd0;
            r_trig_type <= 2'b00;
            r_seq_err   <= 1'b0;
            r_fmt_err   <= 1'b0;
        end else begin
            r_seq_err <= 1'b0;
            r_fmt_err <= 1'b0;

            if ((r_state == IDLE) && bus.fifo_valid) begin
                r_word <= bus.fifo_data;
            end

            if (w_fwd) begin
                r_trig_num  <= w_num;
                r_trig_ts   <= w_ts;
                r_trig_type <= w_type;
            end

            if (w_check && w_fmt_bad) begin
                r_fmt_err <= 1'b1;
            end

            // A clear in the CHECK cycle still forwards the record but skips all bookkeeping.
            if (bus.clear_counters) begin
                r_expected  <= 24'd1;
                r_missed    <= 16'd0;
                r_cnt_laser <= 24'd0;
                r_cnt_am    <= 24'd0;
                r_cnt_both  <= 24'd0;
            end else if (w_fwd) begin
                if (w_num != r_expected) begin
                    r_seq_err <= 1'b1;
                    r_missed  <= w_missed_next;
                end
                r_expected <= w_num + 24'd1;
                case (w_type)
                    2'b10:   r_cnt_laser <= r_cnt_laser + 24'd1;
                    2'b01:   r_cnt_am    <= r_cnt_am + 24'd1;
                    2'b11:   r_cnt_both  <= r_cnt_both + 24'd1;
                    default: ;
                endcase
            end
        end
    end

    assign bus.fifo_ready     = w_fifo_ready;
    assign bus.trig_valid     = w_trig_valid;
    assign bus.trig_num       = r_trig_num;
    assign bus.trig_timestamp = r_trig_ts;
    assign bus.trig_type      = r_trig_type;
    assign bus.seq_error      = r_seq_err;
    assign bus.format_error   = r_fmt_err;
    assign bus.missed_count   = r_missed;
    assign bus.cnt_laser      = r_cnt_laser;
    assign bus.cnt_am         = r_cnt_am;
    assign bus.cnt_both       = r_cnt_both;
    assign bus.state          = r_state;

endmodule

// File: tb/tb_pulse_trigger_info_reader.sv
// Directed bench: expected records go to a scoreboard queue, a negedge monitor pops and compares;
// error pulses are tallied by the monitor and compared against hand-computed totals.
module tb_pulse_trigger_info_reader;

`ifdef PTR_HOLDOFF_EN
    localparam bit HO = 1'b1;
`else
    localparam bit HO = 1'b0;
`endif

    typedef struct packed {
        logic [23:0] num;
        logic [43:0] ts;
        logic [1:0]  typ;
        logic        close;
    } rec_t;

    logic clk;
    logic reset_n;
    pulse_trigger_info_reader_if bus ();

    pulse_trigger_info_reader #(.HOLDOFF_CYCLES(44'd8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int   n_vec  = 0;
    int   n_bad  = 0;
    int   n_seq  = 0;
    int   n_fmt  = 0;
    bit   mon_en = 1'b0;
    rec_t sb[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.seq_error)    n_seq++;
            if (bus.format_error) n_fmt++;
            if (bus.trig_valid && bus.trig_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_record", {bus.trig_num, bus.trig_timestamp}, 0);
                end else begin
                    rec_t e;
                    e = sb.pop_front();
                    chk("record", {bus.trig_num, bus.trig_timestamp, bus.trig_type, bus.trig_close}, e);
                end
            end
        end
    end

    function automatic logic [127:0] mk(input logic [1:0] t, input logic [23:0] n, input logic [43:0] ts);
        return {58'd0, t, n, ts};
    endfunction

    task automatic push(input logic [127:0] d);
        int t = 0;
        @(negedge clk);
        bus.fifo_valid = 1'b1;
        bus.fifo_data  = d;
        while (!bus.fifo_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("push_timeout", 1, 0);
        @(posedge clk);
        #1;
        bus.fifo_valid = 1'b0;
    endtask

    task automatic send(input logic [1:0] t, input logic [23:0] n, input logic [43:0] ts, input bit close);
        rec_t e;
        e.num = n; e.ts = ts; e.typ = t; e.close = close & HO;
        sb.push_back(e);
        push(mk(t, n, ts));
    endtask

    task automatic settle();
        int t = 0;
        while (!(bus.state == 3'b001 && sb.size() == 0 && !bus.trig_valid) && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) chk("settle_timeout", 1, 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_cnt(input string name, input int l, input int a, input int b, input int m);
        chk(name, {bus.cnt_laser, bus.cnt_am, bus.cnt_both, bus.missed_count},
            {l[23:0], a[23:0], b[23:0], m[15:0]});
    endtask

    initial begin
        reset_n            = 1'b0;
        bus.fifo_valid     = 1'b0;
        bus.fifo_data      = '0;
        bus.clear_counters = 1'b0;
        bus.trig_ready     = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;

        // reset state
        chk("reset_ctl", {bus.state, bus.fifo_ready, bus.trig_valid, bus.trig_close, bus.seq_error, bus.format_error},
            {3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        chk("reset_rec", {bus.trig_num, bus.trig_timestamp, bus.trig_type}, 0);
        chk_cnt("reset_cnt", 0, 0, 0, 0);

        // first record and pop->valid latency
        send(2'b10, 24'd1, 44'd100, 1'b0);
        @(negedge clk);
        chk("lat_check_cycle", {bus.trig_valid, bus.fifo_ready}, {1'b0, 1'b0});
        @(negedge clk);
        chk("lat_send_cycle", bus.trig_valid, 1);
        settle();
        chk_cnt("t1_cnt", 1, 0, 0, 0);
        chk("t1_errs", {n_seq[7:0], n_fmt[7:0]}, 0);

        // sequence gap 2 -> 5
        send(2'b01, 24'd2, 44'd2000, 1'b0);
        send(2'b11, 24'd5, 44'd5000, 1'b0);
        send(2'b10, 24'd6, 44'd6000, 1'b0);
        settle();
        chk("t2_seq", n_seq, 1);
        chk_cnt("t2_cnt", 2, 1, 1, 2);

        // malformed words are dropped without touching counters or expected number
        push(mk(2'b00, 24'd7, 44'd7000));
        push(mk(2'b10, 24'd7, 44'd7000) | (128'd1 << 100));
        settle();
        chk("t3_fmt", n_fmt, 2);
        chk_cnt("t3_cnt", 2, 1, 1, 2);
        send(2'b10, 24'd7, 44'd7000, 1'b0);
        settle();
        chk("t3_seq", n_seq, 1);

        // backpressure: record held, FIFO not popped
        bus.trig_ready = 1'b0;
        send(2'b01, 24'd8, 44'd8000, 1'b0);
        @(negedge clk);
        @(negedge clk);
        fork
            send(2'b11, 24'd9, 44'd9000, 1'b0);
            begin
                for (int i = 0; i < 10; i++) begin
                    chk("hold", {bus.trig_valid, bus.trig_num, bus.trig_timestamp, bus.fifo_ready},
                        {1'b1, 24'd8, 44'd8000, 1'b0});
                    @(negedge clk);
                end
                bus.trig_ready = 1'b1;
            end
        join
        settle();
        chk_cnt("t4_cnt", 3, 2, 2, 2);

        // gap to FFFFFF saturates missed count, then wrap to 0 is continuous
        send(2'b10, 24'hFFFFFF, 44'd20000, 1'b0);
        send(2'b01, 24'd0, 44'd21000, 1'b0);
        settle();
        chk("t5_seq", n_seq, 2);
        chk_cnt("t5_cnt", 4, 3, 2, 16'hFFFF);

        // clear during CHECK: record still forwarded, everything zeroed
        send(2'b11, 24'd50, 44'd22000, 1'b0);
        bus.clear_counters = 1'b1;
        @(posedge clk);
        #1;
        bus.clear_counters = 1'b0;
        settle();
        chk("t5_clr_seq", n_seq, 2);
        chk_cnt("t5_clr_cnt", 0, 0, 0, 0);
        send(2'b10, 24'd1, 44'd23000, 1'b0);
        send(2'b01, 24'd3, 44'd24000, 1'b0);
        settle();
        chk("t5_after_seq", n_seq, 3);
        chk_cnt("t5_after_cnt", 1, 1, 0, 1);

        // holdoff: 5 cycles apart is close, 8 apart is not
        send(2'b10, 24'd4, 44'd100000, 1'b0);
        send(2'b10, 24'd5, 44'd100005, 1'b1);
        send(2'b11, 24'd6, 44'd100013, 1'b0);
        settle();
        chk("t6_seq", n_seq, 3);
        chk("t6_fmt", n_fmt, 2);
        chk_cnt("t6_cnt", 3, 1, 1, 1);
        chk("sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
